// File: rtl/semaforo_pkg.sv
// Shared constants and helpers for the traffic-light phase timer.
// Light vectors are packed as {RED,YLW,GRN}.
package semaforo_pkg;

   localparam logic [2:0] LT_NONE = 3'b000;
   localparam logic [2:0] LT_GRN  = 3'b001;
   localparam logic [2:0] LT_YLW  = 3'b010;
   localparam logic [2:0] LT_RED  = 3'b100;

   localparam int DEF_TICK_DIV  = 50;
   localparam int DEF_T_YLW     = 3;
   localparam int DEF_T_RED     = 15;
   localparam int DEF_T_GRN_MIN = 10;

   // True when exactly one of the three lights is on.
   function automatic logic is_onehot(input logic [2:0] lt);
      return (lt == LT_GRN) || (lt == LT_YLW) || (lt == LT_RED);
   endfunction

   // Largest of three phase durations, used to size the seconds counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/semaforo_tick.sv
// One-second prescaler for the phase timer. Counts clk cycles modulo
// TICK_DIV and flags the last cycle of each second. clear restarts the
// count so that a phase duration is measured from its entry edge.
module semaforo_tick
   import semaforo_pkg::*;
#(
   parameter int TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc;

   // Cycle counter within the current second; wraps on its last value.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         presc <= '0;
      end else if (presc == LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // With TICK_DIV==1 presc is pinned at 0, so every cycle is a tick.
   assign tick = !clear && (presc == LAST);

endmodule

// File: rtl/semaforo_timer.sv
// Phase timer for the Semaforo traffic-light FSM. Measures time spent in
// the current light phase (in prescaled seconds), raises TIMEOUT when the
// yellow or red duration expires, and flags non-one-hot light inputs.
// Optional feature macro SEMAFORO_TIMER_MINGREEN_EN: enforce a minimum
// green time by masking the car request until it has elapsed.
module semaforo_timer
   import semaforo_pkg::*;
#(
   parameter int TICK_DIV  = DEF_TICK_DIV,
   parameter int T_YLW     = DEF_T_YLW,
   parameter int T_RED     = DEF_T_RED,
   parameter int T_GRN_MIN = DEF_T_GRN_MIN,
   localparam int SEC_W    = $clog2(max3(T_YLW, T_RED, T_GRN_MIN) + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             GRN,
   input  logic             YLW,
   input  logic             RED,
   input  logic             CAR,
   output logic             TIMEOUT,
   output logic             CAR_Q,
   output logic [SEC_W-1:0] SEC_LEFT,
   output logic             ERR
);

   logic [2:0]       lt;
   logic [2:0]       lt_q;
   logic             lt_valid;
   logic             entry;
   logic             tick;
   logic [SEC_W-1:0] sec;
   logic [SEC_W-1:0] dur;
   logic             timeout;
   logic             err;

   assign lt       = {RED, YLW, GRN};
   assign lt_valid = is_onehot(lt);
   assign entry    = lt_valid && (lt != lt_q);

   // Prescaler restarts on entry and on illegal input so durations are exact.
   semaforo_tick #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (!lt_valid || entry),
      .tick  (tick)
   );

   // Duration loaded on entry into the phase shown by the light inputs.
   always_comb begin
      dur = '0;
      case (lt)
         LT_YLW:  dur = SEC_W'(T_YLW);
         LT_RED:  dur = SEC_W'(T_RED);
`ifdef SEMAFORO_TIMER_MINGREEN_EN
         LT_GRN:  dur = SEC_W'(T_GRN_MIN);
`endif
         default: dur = '0;
      endcase
   end

   // Phase tracking, seconds countdown, timeout latch and illegal-input flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lt_q    <= LT_NONE;
         sec     <= '0;
         timeout <= 1'b0;
         err     <= 1'b0;
      end else if (!lt_valid) begin
         // Remember the illegal value so the next legal one is an entry.
         lt_q    <= lt;
         sec     <= '0;
         timeout <= 1'b0;
         err     <= 1'b1;
      end else if (entry) begin
         lt_q    <= lt;
         sec     <= dur;
         timeout <= 1'b0;
         err     <= 1'b0;
      end else if (tick && (sec != '0)) begin
         sec <= sec - 1'b1;
         // Green only ever enforces a minimum, it never times out.
         if ((sec == SEC_W'(1)) && (lt_q != LT_GRN)) begin
            timeout <= 1'b1;
         end
      end
   end

`ifdef SEMAFORO_TIMER_MINGREEN_EN
   logic grn_hold;
   assign grn_hold = (lt_q == LT_GRN) && (sec != '0);
   assign CAR_Q    = CAR & ~grn_hold;
`else
   assign CAR_Q    = CAR;
`endif

   assign TIMEOUT  = timeout;
   assign SEC_LEFT = sec;
   assign ERR      = err;

endmodule

// File: tb/tb_semaforo_timer.sv
// Self-checking bench for semaforo_timer. A reference model tracks the
// current phase and the cycles elapsed since its entry; expected outputs
// are derived arithmetically from that elapsed time.
module tb_semaforo_timer;

   localparam int TD = 4;
   localparam int TY = 2;
   localparam int TR = 3;
   localparam int TG = 2;
   localparam int SW = 2;
`ifdef SEMAFORO_TIMER_MINGREEN_EN
   localparam int TGE = TG;
   localparam bit MG  = 1'b1;
`else
   localparam int TGE = 0;
   localparam bit MG  = 1'b0;
`endif

   localparam logic [2:0] P_GRN = 3'b001;
   localparam logic [2:0] P_YLW = 3'b010;
   localparam logic [2:0] P_RED = 3'b100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          grn = 1'b0;
   logic          ylw = 1'b0;
   logic          red = 1'b0;
   logic          car = 1'b0;
   logic          timeout;
   logic          car_q;
   logic          err;
   logic [SW-1:0] sec_left;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   logic [2:0] m_lt = 3'b000;
   int         m_el = 0;
   bit         m_err = 1'b0;

   semaforo_timer #(
      .TICK_DIV  (TD),
      .T_YLW     (TY),
      .T_RED     (TR),
      .T_GRN_MIN (TG)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .GRN      (grn),
      .YLW      (ylw),
      .RED      (red),
      .CAR      (car),
      .TIMEOUT  (timeout),
      .CAR_Q    (car_q),
      .SEC_LEFT (sec_left),
      .ERR      (err)
   );

   always #5 clk = ~clk;

   function automatic int dur_of(input logic [2:0] lt);
      case (lt)
         P_GRN:   return TGE;
         P_YLW:   return TY;
         P_RED:   return TR;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_sec();
      int d, t;
      if (m_err || ($countones(m_lt) != 1)) return 0;
      d = dur_of(m_lt);
      t = m_el / TD;
      return (t >= d) ? 0 : d - t;
   endfunction

   function automatic logic exp_to();
      if (m_err) return 1'b0;
      if ((m_lt != P_YLW) && (m_lt != P_RED)) return 1'b0;
      return (m_el / TD) >= dur_of(m_lt);
   endfunction

   function automatic logic exp_carq();
      return car && !(MG && (m_lt == P_GRN) && (exp_sec() != 0));
   endfunction

   // Drive one cycle of inputs, let the edge happen, advance the model,
   // and settle just after the edge for sampling.
   task automatic apply(input logic r, input logic [2:0] lt, input logic c);
      rst_n = r;
      {red, ylw, grn} = lt;
      car = c;
      @(posedge clk);
      if (!r) begin
         m_lt = 3'b000; m_el = 0; m_err = 1'b0;
      end else if ($countones(lt) != 1) begin
         m_err = 1'b1; m_lt = lt; m_el = 0;
      end else if (lt != m_lt) begin
         m_lt = lt; m_el = 0; m_err = 1'b0;
      end else begin
         m_el++;
      end
      #1;
   endtask

   task automatic test_reset();
      apply(1'b0, P_GRN, 1'b0);
      apply(1'b0, P_GRN, 1'b1);
      vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout got %b want 0", timeout); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
      vectors++; if (sec_left !== '0) begin miscompares++; $display("FAIL reset_sec got %0d want 0", sec_left); end
      vectors++; if (car_q !== 1'b1) begin miscompares++; $display("FAIL reset_carq got %b want 1", car_q); end
   endtask

   task automatic test_green_min();
      for (int i = 0; i < 14; i++) begin
         apply(1'b1, P_GRN, (i < 2) ? 1'b1 : logic'($urandom_range(0, 1)));
         vectors++; if (timeout !== exp_to()) begin miscompares++; $display("FAIL grn_timeout cyc %0d got %b want %b", i, timeout, exp_to()); end
         vectors++; if (err !== m_err) begin miscompares++; $display("FAIL grn_err cyc %0d got %b want %b", i, err, m_err); end
         vectors++; if (sec_left !== SW'(exp_sec())) begin miscompares++; $display("FAIL grn_sec cyc %0d got %0d want %0d", i, sec_left, exp_sec()); end
         vectors++; if (car_q !== exp_carq()) begin miscompares++; $display("FAIL grn_carq cyc %0d got %b want %b", i, car_q, exp_carq()); end
      end
   endtask

   task automatic test_yellow_hold();
      for (int i = 0; i < 29; i++) begin
         apply(1'b1, P_YLW, logic'($urandom_range(0, 1)));
         vectors++; if (timeout !== exp_to()) begin miscompares++; $display("FAIL ylw_timeout cyc %0d got %b want %b", i, timeout, exp_to()); end
         vectors++; if (sec_left !== SW'(exp_sec())) begin miscompares++; $display("FAIL ylw_sec cyc %0d got %0d want %0d", i, sec_left, exp_sec()); end
         vectors++; if (car_q !== exp_carq()) begin miscompares++; $display("FAIL ylw_carq cyc %0d got %b want %b", i, car_q, exp_carq()); end
         if (i >= 2 * TD) begin
            vectors++; if (timeout !== 1'b1) begin miscompares++; $display("FAIL ylw_held cyc %0d got %b want 1", i, timeout); end
         end
      end
   endtask

   task automatic test_early_exit();
      for (int i = 0; i < 16; i++) begin
         apply(1'b1, (i < 6) ? P_RED : P_GRN, logic'($urandom_range(0, 1)));
         vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL early_timeout cyc %0d got %b want 0", i, timeout); end
         vectors++; if (sec_left !== SW'(exp_sec())) begin miscompares++; $display("FAIL early_sec cyc %0d got %0d want %0d", i, sec_left, exp_sec()); end
         vectors++; if (car_q !== exp_carq()) begin miscompares++; $display("FAIL early_carq cyc %0d got %b want %b", i, car_q, exp_carq()); end
      end
   endtask

   task automatic test_illegal();
      for (int i = 0; i < 17; i++) begin
         apply(1'b1, (i < 3) ? 3'b011 : P_RED, logic'($urandom_range(0, 1)));
         vectors++; if (err !== m_err) begin miscompares++; $display("FAIL ill_err cyc %0d got %b want %b", i, err, m_err); end
         vectors++; if (timeout !== exp_to()) begin miscompares++; $display("FAIL ill_timeout cyc %0d got %b want %b", i, timeout, exp_to()); end
         vectors++; if (sec_left !== SW'(exp_sec())) begin miscompares++; $display("FAIL ill_sec cyc %0d got %0d want %0d", i, sec_left, exp_sec()); end
      end
   endtask

   task automatic test_reset_mid();
      apply(1'b0, P_RED, 1'b0);
      vectors++; if ({timeout, err, car_q, sec_left} !== '0) begin miscompares++; $display("FAIL rstmid_outputs got %b want 0", {timeout, err, car_q, sec_left}); end
      for (int i = 0; i < 15; i++) begin
         apply(1'b1, P_RED, 1'b0);
         vectors++; if (timeout !== exp_to()) begin miscompares++; $display("FAIL rstmid_timeout cyc %0d got %b want %b", i, timeout, exp_to()); end
         vectors++; if (sec_left !== SW'(exp_sec())) begin miscompares++; $display("FAIL rstmid_sec cyc %0d got %0d want %0d", i, sec_left, exp_sec()); end
      end
   endtask

   task automatic test_random();
      logic [2:0] illegal [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
      logic [2:0] ph;
      int         len;
      logic       r;
      for (int s = 0; s < 40; s++) begin
         case ($urandom_range(0, 4))
            0:       ph = P_GRN;
            1:       ph = P_YLW;
            2:       ph = P_RED;
            3:       ph = (($urandom_range(0, 2) == 0)) ? illegal[$urandom_range(0, 4)] : P_RED;
            default: ph = P_YLW;
         endcase
         len = $urandom_range(1, 16);
         for (int i = 0; i < len; i++) begin
            r = ($urandom_range(0, 39) != 0);
            apply(r, ph, logic'($urandom_range(0, 1)));
            vectors++; if (timeout !== exp_to()) begin miscompares++; $display("FAIL rnd_timeout seg %0d cyc %0d got %b want %b", s, i, timeout, exp_to()); end
            vectors++; if (err !== m_err) begin miscompares++; $display("FAIL rnd_err seg %0d cyc %0d got %b want %b", s, i, err, m_err); end
            vectors++; if (sec_left !== SW'(exp_sec())) begin miscompares++; $display("FAIL rnd_sec seg %0d cyc %0d got %0d want %0d", s, i, sec_left, exp_sec()); end
            vectors++; if (car_q !== exp_carq()) begin miscompares++; $display("FAIL rnd_carq seg %0d cyc %0d got %b want %b", s, i, car_q, exp_carq()); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_green_min();
      test_yellow_hold();
      test_early_exit();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/semaforo_timer.md
# semaforo_timer

Phase timer that drives the `TIMEOUT` input of the `Semaforo` traffic-light FSM. It watches the FSM's one-hot light outputs (`GRN`, `YLW`, `RED`) and measures the time spent in each phase, counted in prescaled seconds. It raises `TIMEOUT` when the programmed duration for the current phase expires. It also qualifies the car-detector request so the FSM cannot leave green before a minimum green time has elapsed.

## Interface
- `TICK_DIV`, default 50: `clk` cycles per one-second tick; must be ≥1.
- `T_YLW`, default 3: yellow duration in ticks; must be ≥1.
- `T_RED`, default 15: red duration in ticks; must be ≥1.
- `T_GRN_MIN`, default 10: minimum green duration in ticks; must be ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `GRN` in 1: light-state input from the FSM.
- `YLW` in 1: light-state input from the FSM.
- `RED` in 1: light-state input from the FSM.
- `CAR` in 1: raw car-detector request.
- `TIMEOUT` out 1: registered level; high while the current phase duration has expired.
- `CAR_Q` out 1: qualified car request, to be fed to the FSM's `CAR` input.
- `SEC_LEFT` out `SEC_W`: ticks remaining in the current phase. `SEC_W = $clog2(max(T_YLW,T_RED,T_GRN_MIN)+1)`.
- `ERR` out 1: registered; high while the light inputs are not one-hot.

## Operation
- **Internal state**
  - `lt_q`: last sampled `{RED,YLW,GRN}`.
  - `presc`: 0..TICK_DIV-1.
  - `sec`: drives `SEC_LEFT`.
- **Entry detection**: a rising edge with a valid one-hot input that differs from `lt_q` is an entry. On entry:
  - `presc` ← 0.
  - `sec` ← duration of the new phase: YLW→`T_YLW`, RED→`T_RED`, GRN→`T_GRN_MIN` (with the configuration macro) or 0 (without it).
  - `TIMEOUT` ← 0.
- **Counting**: with no entry and a valid input, `presc` increments each cycle.
  - At `presc==TICK_DIV-1`, `presc` wraps to 0 and, if `sec>0`, `sec` decrements.
  - With `TICK_DIV==1`, every cycle is a tick.
- **TIMEOUT**
  - Set on the edge where `sec` becomes 0 in YLW or RED.
  - Stays high until the next entry, ERR, or reset.
  - Never asserted in GRN.
- **Expired phase held**: if the FSM stays in a phase after expiry, `sec` holds at 0 and `TIMEOUT` stays high.
- **Phase left early**: an entry before expiry reloads the counter; no `TIMEOUT` pulse occurs.
- **Illegal input** (zero or multiple lights set):
  - `ERR` ← 1, `TIMEOUT` ← 0, `sec` ← 0, `presc` ← 0, `lt_q` ← the illegal value.
  - The next valid input therefore counts as an entry, and `ERR` clears on that edge.
- **Reset**: while `rst_n` is low at an edge, `lt_q`=000, `presc`=0, `sec`=0, `TIMEOUT`=0, `ERR`=0. The first valid input after reset is an entry.

## Timing
- Entry sampled at edge E → `TIMEOUT` high after edge E + T·TICK_DIV. The duration is exact because `presc` restarts on entry.
- `SEC_LEFT` equals `T` after edge E and decrements after edges E + k·TICK_DIV, for k = 1..T.
- `ERR` and `TIMEOUT` both have one cycle of latency from the input change.
- `CAR_Q` is combinational from `CAR` and registered state; it adds no cycle of latency.
- Reset mid-phase takes priority over everything else; it is effective on the same edge.

## Configuration
- **With `SEMAFORO_TIMER_MINGREEN_EN` defined**
  - Entry to GRN loads `T_GRN_MIN`.
  - `CAR_Q = CAR & ~(lt_q==GRN & sec!=0)`, i.e. the request is masked until minimum green has elapsed.
  - Outside GRN, `CAR_Q = CAR`.
- **Without it**
  - GRN loads 0.
  - `CAR_Q = CAR` unconditionally.
  - The green comparison logic is not synthesized.

## Structure
- **Package `semaforo_pkg`** holds:
  - Light encoding constants: `LT_GRN`=3'b001, `LT_YLW`=3'b010, `LT_RED`=3'b100 in `{RED,YLW,GRN}` order.
  - Default duration constants.
  - A one-hot check function.
- **Sub-module `semaforo_tick`**: prescaler with `clear` input and `tick` output, parameterized by `TICK_DIV`.

## Test plan
All scenarios use TICK_DIV=4, T_YLW=2, T_RED=3, T_GRN_MIN=2, with the macro defined.
1. Reset, then GRN=1 → `TIMEOUT`=0 and `ERR`=0 throughout. `SEC_LEFT` goes 2→1→0 after 4 and 8 cycles. `CAR_Q` is forced to 0 before cycle 8, then follows `CAR`.
2. YLW entry at edge E → `TIMEOUT` rises after edge E+8 and stays high while YLW is held 20 more cycles.
3. RED entry, then back to GRN at E+6 → no `TIMEOUT`. `SEC_LEFT` reloads to 2.
4. Inputs 011 for 3 cycles → `ERR`=1 and `TIMEOUT`=0 one cycle later. Then RED=1 → `ERR`=0 and `SEC_LEFT`=3; `TIMEOUT` follows at +12.
5. `rst_n` low for one edge with RED expired (`TIMEOUT`=1) → all outputs 0. RED is treated as a fresh entry, with `TIMEOUT` after 12 cycles.
6. Rebuild without the macro → GRN gives `SEC_LEFT`=0 and `CAR_Q` mirrors `CAR` on the same cycle.
